// File: rtl/channel_buffer_pkg.sv
// Shared definitions for the channel buffer reader/writer pair:
// default geometry, header tag and the reader FSM state encoding.
package channel_buffer_pkg;

  localparam int NUM_CHANNELS_DEFAULT = 14;
  localparam int SAMPLE_BITS_DEFAULT  = 8;
  localparam int DEPTH_DEFAULT        = 10;

  localparam logic [3:0] HEADER_TAG = 4'hA;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    RD,
    CAP,
    DAT,
    DONE
  } state_t;

  // Index width that never collapses to zero bits for single-entry ranges.
  function automatic int safe_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/channel_buffer_reader_finder.sv
// Combinational search for the lowest set mask bit above (or, when
// i_inclusive is set, at or above) the given channel.
module next_channel_finder
  import channel_buffer_pkg::*;
#(
  parameter int NUM_CHANNELS = NUM_CHANNELS_DEFAULT,
  parameter int CHAN_W       = safe_clog2(NUM_CHANNELS)
) (
  input  logic [NUM_CHANNELS-1:0] i_mask,
  input  logic [CHAN_W-1:0]       i_chan,
  input  logic                    i_inclusive,
  output logic                    o_found,
  output logic [CHAN_W-1:0]       o_chan
);

  // Scan from the top down so the lowest qualifying bit is written last.
  always_comb begin
    o_found = 1'b0;
    o_chan  = '0;
    for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
      if (i_mask[i] && ((i > int'(i_chan)) || (i_inclusive && (i == int'(i_chan))))) begin
        o_found = 1'b1;
        o_chan  = CHAN_W'(i);
      end
    end
  end

endmodule

// File: rtl/channel_buffer_reader.sv
// Dumps the selected channels of the sample buffer store as a byte stream:
// one header byte per channel followed by its DEPTH samples, oldest first.
module channel_buffer_reader
  import channel_buffer_pkg::*;
#(
  parameter int NUM_CHANNELS = NUM_CHANNELS_DEFAULT,
  parameter int SAMPLE_BITS  = SAMPLE_BITS_DEFAULT,
  parameter int DEPTH        = DEPTH_DEFAULT,
  localparam int CHAN_W      = safe_clog2(NUM_CHANNELS),
  localparam int IDX_W       = safe_clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_start,
  input  logic                    i_abort,
  input  logic [NUM_CHANNELS-1:0] i_chan_mask,
  output logic                    o_mem_rd_en,
  output logic [CHAN_W-1:0]       o_mem_rd_chan,
  output logic [IDX_W-1:0]        o_mem_rd_idx,
  input  logic [SAMPLE_BITS-1:0]  i_mem_rd_data,
  output logic [SAMPLE_BITS-1:0]  o_out_data,
  output logic                    o_out_valid,
  input  logic                    i_out_ready,
  output logic                    o_out_last,
  output logic                    o_busy,
  output logic                    o_done
);

  state_t                  r_state, w_state_next;
  logic [NUM_CHANNELS-1:0] r_mask, w_mask_next;
  logic [CHAN_W-1:0]       r_chan, w_chan_next;
  logic [IDX_W-1:0]        r_idx, w_idx_next;
  logic [SAMPLE_BITS-1:0]  r_hold, w_hold_next;

  logic                    w_first_found, w_next_found;
  logic [CHAN_W-1:0]       w_first_chan, w_next_chan;
  logic                    w_idx_last;
  logic [SAMPLE_BITS-1:0]  w_header;

  next_channel_finder #(
    .NUM_CHANNELS(NUM_CHANNELS),
    .CHAN_W      (CHAN_W)
  ) u_first_finder (
    .i_mask     (i_chan_mask),
    .i_chan     ('0),
    .i_inclusive(1'b1),
    .o_found    (w_first_found),
    .o_chan     (w_first_chan)
  );

  next_channel_finder #(
    .NUM_CHANNELS(NUM_CHANNELS),
    .CHAN_W      (CHAN_W)
  ) u_next_finder (
    .i_mask     (r_mask),
    .i_chan     (r_chan),
    .i_inclusive(1'b0),
    .o_found    (w_next_found),
    .o_chan     (w_next_chan)
  );

  assign w_idx_last = (r_idx == IDX_W'(DEPTH - 1));
  assign w_header   = SAMPLE_BITS'({HEADER_TAG, r_chan});

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_mask  <= '0;
      r_chan  <= '0;
      r_idx   <= '0;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_next;
      r_mask  <= w_mask_next;
      r_chan  <= w_chan_next;
      r_idx   <= w_idx_next;
      r_hold  <= w_hold_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_mask_next  = r_mask;
    w_chan_next  = r_chan;
    w_idx_next   = r_idx;
    w_hold_next  = r_hold;
    o_mem_rd_en  = 1'b0;
    o_out_valid  = 1'b0;
    o_out_last   = 1'b0;
    o_done       = 1'b0;

    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_mask_next = i_chan_mask;
          if (w_first_found) begin
            w_chan_next  = w_first_chan;
            w_state_next = HDR;
          end else begin
            w_state_next = DONE;
          end
        end
      end
      HDR: begin
        o_out_valid = 1'b1;
        if (i_out_ready) begin
          w_idx_next   = '0;
          w_state_next = RD;
        end
      end
      RD: begin
        o_mem_rd_en  = 1'b1;
        w_state_next = CAP;
      end
      CAP: begin
        w_hold_next  = i_mem_rd_data;
        w_state_next = DAT;
      end
      DAT: begin
        o_out_valid = 1'b1;
        o_out_last  = w_idx_last;
        if (i_out_ready) begin
          if (!w_idx_last) begin
            w_idx_next   = r_idx + IDX_W'(1);
            w_state_next = RD;
          end else if (w_next_found) begin
            w_chan_next  = w_next_chan;
            w_state_next = HDR;
          end else begin
            w_state_next = DONE;
          end
        end
      end
      DONE: begin
        o_done       = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase

    // Abort wins over any transfer completing in the same cycle.
    if (i_abort && (r_state != IDLE)) begin
      w_state_next = IDLE;
    end
  end

  assign o_busy        = (r_state != IDLE);
  assign o_mem_rd_chan = r_chan;
  assign o_mem_rd_idx  = r_idx;
  assign o_out_data    = (r_state == HDR) ? w_header : r_hold;

endmodule

// File: tb/tb_channel_buffer_reader.sv
// Randomized bench for channel_buffer_reader: a behavioural buffer store and
// an expected byte stream built directly from the mask and store contents.
module tb_channel_buffer_reader;

  localparam int NCH    = 14;
  localparam int SB     = 8;
  localparam int DEP    = 10;
  localparam int CW     = 4;
  localparam int IW     = 4;
  localparam int BUDGET = 3000;

  logic           clk = 1'b0;
  logic           reset;
  logic           iStart, iAbort, iOutReady;
  logic [NCH-1:0] iChanMask;
  logic           oMemRdEn, oOutValid, oOutLast, oBusy, oDone;
  logic [CW-1:0]  oMemRdChan;
  logic [IW-1:0]  oMemRdIdx;
  logic [SB-1:0]  memRdData, oOutData;

  logic [SB-1:0]  store [NCH][DEP];

  int checks = 0;
  int errors = 0;

  channel_buffer_reader #(
    .NUM_CHANNELS(NCH),
    .SAMPLE_BITS (SB),
    .DEPTH       (DEP)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .i_start      (iStart),
    .i_abort      (iAbort),
    .i_chan_mask  (iChanMask),
    .o_mem_rd_en  (oMemRdEn),
    .o_mem_rd_chan(oMemRdChan),
    .o_mem_rd_idx (oMemRdIdx),
    .i_mem_rd_data(memRdData),
    .o_out_data   (oOutData),
    .o_out_valid  (oOutValid),
    .i_out_ready  (iOutReady),
    .o_out_last   (oOutLast),
    .o_busy       (oBusy),
    .o_done       (oDone)
  );

  always #5 clk = ~clk;

  // Store answers one cycle after a read strobe; junk otherwise.
  always @(posedge clk) begin
    if (oMemRdEn && (int'(oMemRdChan) < NCH) && (int'(oMemRdIdx) < DEP))
      memRdData <= store[oMemRdChan][oMemRdIdx];
    else
      memRdData <= 8'($urandom);
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic fillStore(input bit ch0Ramp);
    for (int ch = 0; ch < NCH; ch++)
      for (int k = 0; k < DEP; k++)
        store[ch][k] = (ch0Ramp && ch == 0) ? 8'(8'h10 + k) : 8'($urandom);
  endtask

  task automatic applyStimulus(input logic [NCH-1:0] mask, input int readyPct);
    logic [8:0] expQ[$];
    logic [8:0] obsQ[$];
    logic [8:0] prevOut;
    logic       prevStall, rdy;
    int pop, reads, badReads, doneCount, doneCycle, busyCycles, validCycles, firstValid;
    pop = 0; reads = 0; badReads = 0; doneCount = 0; doneCycle = 0;
    busyCycles = 0; validCycles = 0; firstValid = 0; prevStall = 1'b0; prevOut = '0;

    for (int ch = 0; ch < NCH; ch++) begin
      if (mask[ch]) begin
        pop++;
        expQ.push_back({1'b0, 8'hA0 + 8'(ch)});
        for (int k = 0; k < DEP; k++)
          expQ.push_back({(k == DEP - 1), store[ch][k]});
      end
    end

    iChanMask = mask;
    iStart    = 1'b1;
    iOutReady = 1'b0;
    for (int c = 1; c <= BUDGET; c++) begin
      @(negedge clk);
      iStart = 1'b0;
      if (c == 2 && mask != 0) begin
        iStart    = 1'b1;
        iChanMask = ~mask;
      end
      if (prevStall) begin
        checkOutput("stallValid", 32'(oOutValid), 32'd1);
        checkOutput("stallData", 32'({oOutLast, oOutData}), 32'(prevOut));
      end
      if (oOutValid) begin
        validCycles++;
        if (firstValid == 0) firstValid = c;
      end
      if (oMemRdEn) begin
        reads++;
        if (int'(oMemRdChan) >= NCH || !mask[oMemRdChan]) badReads++;
      end
      if (oBusy) busyCycles++;
      if (oDone) begin
        doneCount++;
        if (doneCycle == 0) doneCycle = c;
      end
      rdy = ($urandom_range(99) < readyPct);
      iOutReady = rdy;
      if (oOutValid && rdy) obsQ.push_back({oOutLast, oOutData});
      prevStall = oOutValid && !rdy;
      prevOut   = {oOutLast, oOutData};
      if (doneCycle != 0 && c >= doneCycle + 3) break;
    end
    iOutReady = 1'b0;
    iChanMask = mask;

    checkOutput("doneSeen", 32'(doneCycle != 0), 32'd1);
    checkOutput("doneCount", 32'(doneCount), 32'd1);
    checkOutput("byteCount", 32'(obsQ.size()), 32'(expQ.size()));
    for (int i = 0; i < expQ.size() && i < obsQ.size(); i++)
      checkOutput($sformatf("byte%0d", i), 32'(obsQ[i]), 32'(expQ[i]));
    checkOutput("reads", 32'(reads), 32'(pop * DEP));
    checkOutput("badReads", 32'(badReads), 32'd0);
    checkOutput("busyCycles", 32'(busyCycles), 32'(doneCycle));
    if (readyPct == 100)
      checkOutput("doneCycle", 32'(doneCycle), 32'(1 + pop * (1 + 3 * DEP)));
    if (readyPct == 100 && pop > 0)
      checkOutput("headerCycle", 32'(firstValid), 32'd1);
    if (pop == 0)
      checkOutput("validCycles", 32'(validCycles), 32'd0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "Valid"}, 32'(oOutValid), 32'd0);
    checkOutput({tag, "Last"}, 32'(oOutLast), 32'd0);
    checkOutput({tag, "Data"}, 32'(oOutData), 32'd0);
    checkOutput({tag, "RdEn"}, 32'(oMemRdEn), 32'd0);
    checkOutput({tag, "RdChan"}, 32'(oMemRdChan), 32'd0);
    checkOutput({tag, "RdIdx"}, 32'(oMemRdIdx), 32'd0);
    checkOutput({tag, "Busy"}, 32'(oBusy), 32'd0);
    checkOutput({tag, "Done"}, 32'(oDone), 32'd0);
  endtask

  initial begin
    int abReads, abDones;
    reset = 1'b1; iStart = 1'b0; iAbort = 1'b0; iOutReady = 1'b0; iChanMask = '0;
    repeat (3) @(negedge clk);
    checkResetOutputs("init");
    reset = 1'b0;
    @(negedge clk);

    fillStore(1'b1);
    applyStimulus(14'h0001, 100);
    applyStimulus(14'h2005, 100);
    applyStimulus(14'h0000, 100);
    applyStimulus(14'h0001, 30);

    // Abort while the fourth sample of channel 0 is on the bus.
    abReads = 0; abDones = 0;
    iChanMask = 14'h0001; iStart = 1'b1; iOutReady = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      iStart = 1'b0;
    end
    checkOutput("abortSample", 32'({oOutValid, oOutData}), 32'({1'b1, store[0][3]}));
    iAbort = 1'b1;
    @(negedge clk);
    iAbort = 1'b0;
    checkOutput("abortValid", 32'(oOutValid), 32'd0);
    checkOutput("abortBusy", 32'(oBusy), 32'd0);
    for (int c = 0; c < 40; c++) begin
      if (oMemRdEn) abReads++;
      if (oDone) abDones++;
      @(negedge clk);
    end
    checkOutput("abortReads", 32'(abReads), 32'd0);
    checkOutput("abortDone", 32'(abDones), 32'd0);
    iOutReady = 1'b0;
    applyStimulus(14'h0001, 100);

    // Reset in DAT while stalled, with start and abort also high.
    iChanMask = 14'h2005; iStart = 1'b1; iOutReady = 1'b1;
    @(negedge clk);
    iStart = 1'b0;
    @(negedge clk);
    iOutReady = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("preResetValid", 32'(oOutValid), 32'd1);
    reset = 1'b1; iStart = 1'b1; iAbort = 1'b1;
    @(negedge clk);
    checkResetOutputs("midReset");
    reset = 1'b0; iStart = 1'b0; iAbort = 1'b0;
    @(negedge clk);
    checkOutput("postResetBusy", 32'(oBusy), 32'd0);

    for (int r = 0; r < 4; r++) begin
      fillStore(1'b0);
      applyStimulus(NCH'($urandom), (r % 2 == 0) ? 100 : 30 + int'($urandom_range(40)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
